if_id_frontend: RTL and testbench

//  Fetch-side consumer of the hazard unit's stall/flush controls: owns the PC register and the IF/ID

---
 rtl/if_id_frontend_pkg.sv | 27 ++
 rtl/if_id_frontend_sat_counter.sv | 18 +
 rtl/if_id_frontend.sv | 88 ++++++++
 tb/tb_if_id_frontend.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/if_id_frontend_pkg.sv
// Shared definitions for the fetch front end: ISA widths, reset/bubble constants
// and the next-PC source encoding.
package if_id_frontend_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RV_NOP_INST = 32'h0000_0013;
   localparam logic [XLEN-1:0] RV_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_STEP     = 2'd0,
      PC_HOLD     = 2'd1,
      PC_REDIRECT = 2'd2
   } pc_sel_e;

   // Older branch/jump in MEM outranks a data stall; any other hazard freezes fetch.
   function automatic pc_sel_e pc_select(input logic en_if, input logic nop_ifid,
                                         input logic ctrl_stall, input logic taken);
      if (ctrl_stall && taken)
         return PC_REDIRECT;
      else if (!en_if || ctrl_stall || nop_ifid)
         return PC_HOLD;
      else
         return PC_STEP;
   endfunction

endpackage

// File: rtl/if_id_frontend_sat_counter.sv
// Saturating up-counter used for hazard performance statistics; sticks at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/if_id_frontend.sv
// Fetch front end: PC register, next-PC mux, IF/ID pipeline register and
// saturating hazard counters driven by the hazard unit's stall/flush controls.
module if_id_frontend
   import if_id_frontend_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RV_RESET_PC,
   parameter logic [XLEN-1:0] NOP_INST = RV_NOP_INST,
   parameter int              CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_IF,
   input  logic             en_IFID,
   input  logic             NOP_IFID,
   input  logic             Control_stall_IF,
   input  logic             Branch_taken,
   input  logic [XLEN-1:0]  Branch_target,
   input  logic [XLEN-1:0]  inst_in,
   output logic [XLEN-1:0]  PC_out,
   output logic [XLEN-1:0]  PC_out_IFID,
   output logic [XLEN-1:0]  inst_out_IFID,
   output logic             valid_out_IFID,
   output logic [CNT_W-1:0] data_stall_cnt,
   output logic [CNT_W-1:0] ctrl_flush_cnt,
   output logic [CNT_W-1:0] redirect_cnt
);

   pc_sel_e         pc_sel;
   logic [XLEN-1:0] pc_next;
   logic            bubble_ifid;

   assign pc_sel      = pc_select(en_IF, NOP_IFID, Control_stall_IF, Branch_taken);
   // A stalled ID instruction is never squashed, so a bubble only lands when ID may advance.
   assign bubble_ifid = en_IFID && NOP_IFID;

   always_comb begin
      pc_next = PC_out;
      case (pc_sel)
         PC_REDIRECT: pc_next = Branch_target;
         PC_STEP:     pc_next = PC_out + XLEN'(4);
         default:     pc_next = PC_out;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         PC_out <= RESET_PC;
      else
         PC_out <= pc_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PC_out_IFID    <= '0;
         inst_out_IFID  <= NOP_INST;
         valid_out_IFID <= 1'b0;
      end else if (bubble_ifid) begin
         inst_out_IFID  <= NOP_INST;
         valid_out_IFID <= 1'b0;
      end else if (en_IFID) begin
         PC_out_IFID    <= PC_out;
         inst_out_IFID  <= inst_in;
         valid_out_IFID <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_data_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (!en_IF),
      .cnt (data_stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_ctrl_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (bubble_ifid),
      .cnt (ctrl_flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_redirect_cnt (
      .clk (clk),
      .rst (rst),
      .inc (pc_sel == PC_REDIRECT),
      .cnt (redirect_cnt)
   );

endmodule

// File: tb/tb_if_id_frontend.sv
// Directed bench for if_id_frontend: per-cycle vector table plus reset and
// counter-saturation sequences on a narrow-counter second instance.
module tb_if_id_frontend;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_if, en_ifid, nop_ifid, ctrl_stall, taken;
   logic [31:0] target, inst_in;
   logic [31:0] pc_out, pc_ifid, inst_ifid;
   logic        valid_ifid;
   logic [31:0] ds_cnt, cf_cnt, rd_cnt;

   logic        en_if2;
   logic [31:0] pc2, pc_ifid2, inst_ifid2;
   logic        valid2;
   logic [1:0]  ds2, cf2, rd2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Instruction memory stand-in: two fixed words, then an address-derived pattern.
   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a == 32'h0) return 32'h00A0_0093;
      if (a == 32'h4) return 32'h0010_0113;
      return (a << 12) | 32'h93;
   endfunction

   assign inst_in = imem(pc_out);

   if_id_frontend dut (
      .clk(clk), .rst(rst), .en_IF(en_if), .en_IFID(en_ifid), .NOP_IFID(nop_ifid),
      .Control_stall_IF(ctrl_stall), .Branch_taken(taken), .Branch_target(target),
      .inst_in(inst_in), .PC_out(pc_out), .PC_out_IFID(pc_ifid),
      .inst_out_IFID(inst_ifid), .valid_out_IFID(valid_ifid),
      .data_stall_cnt(ds_cnt), .ctrl_flush_cnt(cf_cnt), .redirect_cnt(rd_cnt)
   );

   if_id_frontend #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en_IF(en_if2), .en_IFID(1'b1), .NOP_IFID(1'b0),
      .Control_stall_IF(1'b0), .Branch_taken(1'b0), .Branch_target(32'h0),
      .inst_in(32'h0), .PC_out(pc2), .PC_out_IFID(pc_ifid2),
      .inst_out_IFID(inst_ifid2), .valid_out_IFID(valid2),
      .data_stall_cnt(ds2), .ctrl_flush_cnt(cf2), .redirect_cnt(rd2)
   );

   typedef struct {
      logic        en_if, en_ifid, nop, cs, bt;
      logic [31:0] tgt;
      logic [31:0] e_pc, e_ipc, e_inst;
      logic        e_valid;
      logic [31:0] e_ds, e_cf, e_rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic a, b, c, d, e, input logic [31:0] t,
                               input logic [31:0] p, ip, ins, input logic v,
                               input logic [31:0] ds, cf, rd);
      vec_t r;
      r.en_if = a; r.en_ifid = b; r.nop = c; r.cs = d; r.bt = e; r.tgt = t;
      r.e_pc = p; r.e_ipc = ip; r.e_inst = ins; r.e_valid = v;
      r.e_ds = ds; r.e_cf = cf; r.e_rd = rd;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [31:0] p, ip, ins,
                              input logic v, input logic [31:0] ds, cf, rd);
      check({tag, " pc"},    pc_out,     p);
      check({tag, " ipc"},   pc_ifid,    ip);
      check({tag, " inst"},  inst_ifid,  ins);
      check({tag, " valid"}, {31'b0, valid_ifid}, {31'b0, v});
      check({tag, " ds"},    ds_cnt,     ds);
      check({tag, " cf"},    cf_cnt,     cf);
      check({tag, " rd"},    rd_cnt,     rd);
   endtask

   task automatic drive(input logic a, b, c, d, e, input logic [31:0] t);
      en_if = a; en_ifid = b; nop_ifid = c; ctrl_stall = d; taken = e; target = t;
   endtask

   initial begin
      //             en_if en_ifid nop cs bt target        pc            ipc           inst          v  ds cf rd
      vecs.push_back(mk(1,1,0,0,0, 32'h0,         32'h4,        32'h0,        32'h00A00093, 1, 0,0,0)); // straight line
      vecs.push_back(mk(1,1,0,0,0, 32'h0,         32'h8,        32'h4,        32'h00100113, 1, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,         32'h8,        32'h4,        32'h00100113, 1, 1,0,0)); // data stall x3
      vecs.push_back(mk(0,0,0,0,0, 32'h0,         32'h8,        32'h4,        32'h00100113, 1, 2,0,0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,         32'h8,        32'h4,        32'h00100113, 1, 3,0,0));
      vecs.push_back(mk(1,1,0,0,0, 32'h0,         32'hC,        32'h8,        32'h00008093, 1, 3,0,0));
      vecs.push_back(mk(1,1,1,0,0, 32'h0,         32'hC,        32'h8,        32'h00000013, 0, 3,1,0)); // bubbles
      vecs.push_back(mk(1,1,1,0,0, 32'h0,         32'hC,        32'h8,        32'h00000013, 0, 3,2,0));
      vecs.push_back(mk(1,1,1,1,1, 32'h40,        32'h40,       32'h8,        32'h00000013, 0, 3,3,1)); // resolve taken
      vecs.push_back(mk(1,1,0,0,0, 32'h0,         32'h44,       32'h40,       32'h00040093, 1, 3,3,1));
      vecs.push_back(mk(1,0,1,0,0, 32'h0,         32'h44,       32'h40,       32'h00040093, 1, 3,3,1)); // en_IFID=0 beats NOP
      vecs.push_back(mk(1,1,0,1,0, 32'h0,         32'h44,       32'h44,       32'h00044093, 1, 3,3,1)); // not taken: hold
      vecs.push_back(mk(0,1,0,1,1, 32'hFFFFFFFC,  32'hFFFFFFFC, 32'h44,       32'h00044093, 1, 4,3,2)); // redirect beats en_IF=0
      vecs.push_back(mk(1,1,0,0,0, 32'h0,         32'h0,        32'hFFFFFFFC, 32'hFFFFC093, 1, 4,3,2)); // wrap
      vecs.push_back(mk(1,1,0,0,1, 32'h100,       32'h4,        32'h0,        32'h00A00093, 1, 4,3,2)); // taken w/o cs ignored
      vecs.push_back(mk(1,1,0,1,1, 32'h201,       32'h201,      32'h4,        32'h00100113, 1, 4,3,3)); // low bits kept
      vecs.push_back(mk(1,1,0,0,0, 32'h0,         32'h205,      32'h201,      32'h00201093, 1, 4,3,3));

      rst = 1'b1;
      en_if2 = 1'b1;
      drive(1, 1, 0, 0, 0, 32'h0);
      #12;
      rst = 1'b0;
      check_state("reset", 32'h0, 32'h0, 32'h13, 1'b0, 0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].en_if, vecs[i].en_ifid, vecs[i].nop, vecs[i].cs, vecs[i].bt, vecs[i].tgt);
         @(posedge clk);
         #1;
         check_state($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ipc, vecs[i].e_inst,
                     vecs[i].e_valid, vecs[i].e_ds, vecs[i].e_cf, vecs[i].e_rd);
      end

      // Asynchronous reset in mid-cycle while a stall and redirect are pending.
      drive(0, 0, 1, 1, 1, 32'h80);
      #2;
      rst = 1'b1;
      #1;
      check_state("async_rst", 32'h0, 32'h0, 32'h13, 1'b0, 0, 0, 0);
      #1;
      rst = 1'b0;
      drive(1, 1, 0, 0, 0, 32'h0);
      @(posedge clk);
      #1;
      check_state("post_rst", 32'h4, 32'h0, 32'h00A00093, 1'b1, 0, 0, 0);

      // Narrow counter saturation.
      check("sat start", {30'b0, ds2}, 32'd0);
      en_if2 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("sat c%0d", k), {30'b0, ds2}, (k < 3) ? k : 3);
      end
      check("sat pc hold", pc2, 32'h4);
      en_if2 = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
